// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus carrying raw instruction fields in and extended immediates out.
// The slave side belongs to the immediate generator; the master side drives it.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      raw_src;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, raw_src, imm_src, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, raw_src, imm_src, in_tag, out_ready,
        output in_ready, out_valid, imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose: decode-stage immediate generator (I/S/B/U/J/Z) with tag sideband and illegal-select count.
// Latency: one cycle from accept to output when the stage has room to forward directly.
// Backpressure: two-entry skid buffer; in_ready comes from registered state only, never from out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          asm_e;
    logic [24:0]     r;
    logic [31:0]     v32;
    logic [XLEN-1:0] ext;
    logic            err_c;
    logic            acc;
    logic            deq;

    assign r = bus.raw_src;

    // Every format fits in 32 bits, so assemble there and widen afterwards.
    always_comb begin
        v32   = '0;
        err_c = 1'b0;
        case (bus.imm_src)
            3'b000:  v32 = {{20{r[24]}}, r[24:13]};
            3'b001:  v32 = {{20{r[24]}}, r[24:18], r[4:0]};
            3'b010:  v32 = {{19{r[24]}}, r[24], r[0], r[23:18], r[4:1], 1'b0};
            3'b011:  v32 = {r[24:5], 12'b0};
            3'b100:  v32 = {{11{r[24]}}, r[24], r[12:5], r[13], r[23:14], 1'b0};
            3'b101:  v32 = {27'b0, r[12:8]};
            default: err_c = 1'b1;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign ext = {{(XLEN-32){v32[31]}}, v32};
        end else begin : g_narrow
            assign ext = v32;
        end
    endgenerate

    assign asm_e = '{imm: ext, tag: bus.in_tag, err: err_c};

    assign bus.in_ready  = !rst && !flush && (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.imm       = main_q.imm;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_err   = main_q.err;

    assign acc = bus.in_valid && bus.in_ready;
    assign deq = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            illegal_cnt <= '0;
        end else begin
            // Counted at acceptance, so a later flush does not undo it.
            if (acc && err_c && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            main_q <= asm_e;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (acc && deq) begin
                            main_q <= asm_e;
                        end else if (acc) begin
                            skid_q <= asm_e;
                            state  <= TWO;
                        end else if (deq) begin
                            state  <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (deq) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8 instances driven in lockstep.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] raw_src = '0;
    logic [2:0]  imm_src = '0;
    logic [7:0]  in_tag = '0;
    logic [1:0]  cnt_a;
    logic [7:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) ifa ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.raw_src   = raw_src;
    assign ifa.imm_src   = imm_src;
    assign ifa.in_tag    = in_tag;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.raw_src   = raw_src;
    assign ifb.imm_src   = imm_src;
    assign ifb.in_tag    = in_tag;
    assign ifb.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifa), .illegal_cnt(cnt_a)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifb), .illegal_cnt(cnt_b)
    );

    typedef struct {
        logic [24:0] raw;
        logic [2:0]  src;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } ent_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        nxt();
        rst      = 1'b0;
    endtask

    // Reference: rebuild the instruction word and slice fields out of it arithmetically.
    function automatic logic [63:0] ref_imm(input logic [24:0] raw, input logic [2:0] src);
        logic [31:0] instr;
        longint      ins;
        instr = {raw, 7'b0};
        ins   = longint'($signed(instr));
        case (src)
            3'd0: return ins >>> 20;
            3'd1: return ((ins >>> 25) << 5) | ((ins >> 7) & 31);
            3'd2: return ((ins >>> 31) << 12) | (((ins >> 7) & 1) << 11)
                         | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1);
            3'd3: return ins & ~64'hFFF;
            3'd4: return ((ins >>> 31) << 20) | (((ins >> 12) & 255) << 12)
                         | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1);
            3'd5: return (ins >> 15) & 31;
            default: return 64'd0;
        endcase
    endfunction

    vec_t vecs[8];
    ent_t q[$];
    ent_t h;
    int   ea;
    int   eb;
    logic exp_rdy;
    logic dq;

    initial begin
        vecs[0] = '{25'h1FFE001, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1] = '{25'h0FFE001, 3'd0, 64'h00000000000007FF, 1'b0};
        vecs[2] = '{25'h1FC225C, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3] = '{25'h1FC001D, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[4] = '{25'h1000005, 3'd3, 64'hFFFFFFFF80000000, 1'b0};
        vecs[5] = '{25'h1000000, 3'd4, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[6] = '{25'h1FFFFFF, 3'd5, 64'h000000000000001F, 1'b0};
        vecs[7] = '{25'h1FFFFFF, 3'd6, 64'h0000000000000000, 1'b1};

        // Reset state
        #3;
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_imm", ifb.imm, 0);
        chk("rst_tag", ifa.out_tag, 0);
        chk("rst_err", ifa.out_err, 0);
        chk("rst_cnt", cnt_b, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", ifa.in_ready, 1);

        // Format table, single entries with out_ready high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            nxt();
            in_valid = 1'b1;
            raw_src  = vecs[i].raw;
            imm_src  = vecs[i].src;
            in_tag   = 8'(i + 16);
            nxt();
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", ifa.out_valid, 1);
            chk("tbl_imm32", {32'b0, ifa.imm}, {32'b0, vecs[i].e64[31:0]});
            chk("tbl_imm64", ifb.imm, vecs[i].e64);
            chk("tbl_err", ifa.out_err, vecs[i].err);
            chk("tbl_tag", ifb.out_tag, 8'(i + 16));
        end

        // Backpressure: tags 1,2,3 with out_ready low
        nxt();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'd0;
        raw_src   = '0;
        in_tag    = 8'd1;
        @(negedge clk);
        chk("bp_rdy0", ifa.in_ready, 1);
        chk("bp_empty", ifa.out_valid, 0);
        nxt();
        in_tag = 8'd2;
        @(negedge clk);
        chk("bp_rdy1", ifa.in_ready, 1);
        chk("bp_tag1", ifa.out_tag, 1);
        nxt();
        in_tag = 8'd3;
        @(negedge clk);
        chk("bp_full_rdy", ifa.in_ready, 0);
        nxt();
        @(negedge clk);
        chk("bp_hold_rdy", ifb.in_ready, 0);
        chk("bp_hold_tag", ifb.out_tag, 1);
        nxt();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out1", ifa.out_tag, 1);
        nxt();
        @(negedge clk);
        chk("bp_out2", ifa.out_tag, 2);
        chk("bp_rdy_again", ifa.in_ready, 1);
        nxt();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out3", ifa.out_tag, 3);
        chk("bp_out3_vld", ifa.out_valid, 1);
        nxt();
        @(negedge clk);
        chk("bp_drained", ifa.out_valid, 0);

        // Flush while full with an input offered
        nxt();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'd4;
        nxt();
        in_tag = 8'd5;
        nxt();
        in_tag = 8'd6;
        flush  = 1'b1;
        @(negedge clk);
        chk("fl_rdy", ifa.in_ready, 0);
        chk("fl_full", ifa.out_valid, 1);
        nxt();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_empty", ifb.out_valid, 0);
        nxt();
        in_valid = 1'b1;
        in_tag   = 8'd7;
        nxt();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_next_vld", ifa.out_valid, 1);
        chk("fl_next_tag", ifa.out_tag, 7);
        nxt();
        @(negedge clk);
        chk("fl_alone", ifa.out_valid, 0);

        // Illegal selects with a 2-bit saturating counter
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm_src   = 3'd7;
        raw_src   = 25'h1FFFFFF;
        for (int k = 0; k < 5; k++) begin
            nxt();
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
            chk("ill_vld", ifa.out_valid, 1);
            chk("ill_err", ifb.out_err, 1);
            chk("ill_imm32", {32'b0, ifa.imm}, 0);
            chk("ill_imm64", ifb.imm, 0);
        end
        chk("ill_cnt_sat", {62'b0, cnt_a}, 3);
        chk("ill_cnt_wide", {56'b0, cnt_b}, 5);

        // Asynchronous reset while full
        nxt();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'd8;
        nxt();
        imm_src = 3'd0;
        in_tag  = 8'd9;
        nxt();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_full", ifa.in_ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_vld", ifa.out_valid, 0);
        chk("ar_cnt_a", {62'b0, cnt_a}, 0);
        chk("ar_cnt_b", {56'b0, cnt_b}, 0);
        chk("ar_rdy", ifb.in_ready, 0);
        nxt();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 8'd10;
        raw_src   = '0;
        @(negedge clk);
        chk("ar_resume_rdy", ifa.in_ready, 1);
        nxt();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_resume_tag", ifa.out_tag, 10);
        chk("ar_resume_vld", ifb.out_valid, 1);

        // Randomised traffic against a queue model
        do_reset();
        q.delete();
        ea = 0;
        eb = 0;
        for (int n = 0; n < 3000; n++) begin
            nxt();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            raw_src   = 25'($urandom);
            imm_src   = 3'($urandom % 8);
            in_tag    = 8'($urandom);
            @(negedge clk);
            exp_rdy = !flush && (q.size() < 2);
            chk("rnd_rdy_a", ifa.in_ready, exp_rdy);
            chk("rnd_rdy_b", ifb.in_ready, exp_rdy);
            chk("rnd_vld", ifa.out_valid, q.size() > 0);
            chk("rnd_cnt_a", {62'b0, cnt_a}, 64'(ea));
            chk("rnd_cnt_b", {56'b0, cnt_b}, 64'(eb));
            if (q.size() > 0) begin
                h = q[0];
                chk("rnd_imm32", {32'b0, ifa.imm}, {32'b0, h.imm[31:0]});
                chk("rnd_imm64", ifb.imm, h.imm);
                chk("rnd_tag", ifb.out_tag, {56'b0, h.tag});
                chk("rnd_err", ifa.out_err, h.err);
            end
            dq = out_ready && (q.size() > 0);
            if (dq) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && exp_rdy) begin
                h.imm = ref_imm(raw_src, imm_src);
                h.tag = in_tag;
                h.err = imm_src[2] && imm_src[1];
                q.push_back(h);
                if (h.err) begin
                    if (ea < 3)   ea++;
                    if (eb < 255) eb++;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts the 25 upper instruction bits (instr[31:7]), a tag and an immediate-format select, and produces an XLEN-wide extended immediate. Results pass through a registered valid/ready stage with a two-entry skid buffer, so upstream is never stalled combinationally by downstream. It supports all base RV formats (I/S/B/U/J) plus the CSR zero-extended immediate, a flush, and a saturating count of illegal format selects.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- TAG_W, 8: width of the sideband tag carried alongside each immediate (e.g. rd/ROB index).
- CNT_W, 8: width of the illegal-select counter.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transfer request.
- in_ready  out  1  input can be accepted this cycle.
- raw_src  in  25  instr[31:7]; raw_src[i] = instr[i+7].
- imm_src  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 illegal.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts output this cycle.
- imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_err  out  1  entry was produced from an illegal imm_src.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal selects.

## Operation
- Immediate assembly (combinational, before the input register):
  - I: raw[24:13], sign-extended.
  - S: {raw[24:18], raw[4:0]}, sign-extended.
  - B: {raw[24], raw[0], raw[23:18], raw[4:1], 1'b0}, sign-extended (13 bits).
  - U: {raw[24:5], 12'b0}, bit 31 sign-extended to XLEN.
  - J: {raw[24], raw[12:5], raw[13], raw[23:14], 1'b0}, sign-extended (21 bits).
  - Z: raw[12:8] zero-extended.
  - 110/111: imm = 0, err = 1. All legal formats give err = 0.
- Sign extension replicates the format's top bit up to bit XLEN-1. For XLEN=64, U-type bits 63:32 equal bit 31.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Storage: main register (drives outputs) and skid register. The state machine has three states:
  - EMPTY: out_valid=0.
  - ONE: main full, skid empty.
  - TWO: both full.
- in_ready = !rst & !flush & (state != TWO).
- Transitions:
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE (main reloaded).
  - ONE + in, no out -> TWO (input goes to skid).
  - ONE + out, no in -> EMPTY.
  - TWO + out -> ONE (skid moves to main).
  - TWO, no out -> TWO.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.
- flush: next state EMPTY. Any input presented in the same cycle is not accepted (in_ready=0). An output handshake in that cycle still counts as delivered.
- illegal_cnt: increments on each accepted input with imm_src 110/111 and saturates at 2^CNT_W-1. It counts at acceptance, so flushed entries remain counted. Only rst clears it.

## Timing
- Reset values: out_valid=0, imm=0, out_tag=0, out_err=0, illegal_cnt=0, state EMPTY, in_ready=0 while rst high.
- Reset asserted mid-operation clears all entries immediately (asynchronously).
- in_ready is high in the first cycle after rst deasserts.
- Latency: an input accepted in cycle N is on the outputs in cycle N+1 if the buffer was EMPTY, or if it was ONE with out_ready high in cycle N.
- Throughput: one entry per cycle sustained while out_ready=1.
- in_ready depends only on registered state, rst and flush; there is no combinational path from out_ready.
- Output fields are stable while out_valid=1 and out_ready=0.

## Test plan
- I-type: raw_src = instr 0xFFF00093 >> 7, imm_src=000, XLEN=32 -> imm=0xFFFFFFFF one cycle later, out_err=0. With XLEN=64 -> imm=0xFFFFFFFFFFFFFFFF.
- Format sweep: B instr 0xFE000EE3 -> imm=0xFFFFFFFC; J instr 0x0000006F with bit 31 set (0x8000006F) -> imm=0xFFF00000; U instr 0x800002B7 -> imm=0x80000000 (XLEN=64: 0xFFFFFFFF80000000); Z raw[12:8]=5'h1F -> imm=0x1F.
- Backpressure: hold out_ready=0 and push tags 1, 2, 3 -> in_ready falls after 2 accepts and tag 3 is held. Release out_ready -> tags out in order 1, 2, 3, one per cycle.
- Flush: state TWO, assert flush with in_valid=1 -> next cycle out_valid=0 and the new input is not accepted; the next input appears alone.
- Illegal select: CNT_W=2, send 5 inputs with imm_src=111 -> each output has out_err=1 and imm=0; illegal_cnt ends at 3.
- Async reset asserted mid-stream in state TWO -> out_valid=0 and illegal_cnt=0 immediately, without waiting for a clock edge; operation resumes normally after release.
